// File: rtl/mipi_phy_ser_multilane.sv
// Multi-lane D-PHY style serializer: LP-11/LP-01/LP-00 entry, 0xB8 sync, HS payload, trail, exit.
// Clock-lane mode: define MIPI_PHY_SER_MULTILANE_CONT_CLK_EN for a free-running clock lane.
module mipi_phy_ser_multilane #(
   parameter int NUM_DATA_LANES = 1,
   parameter int T_LPX          = 2,
   parameter int T_PREPARE      = 1,
   parameter int T_TRAIL        = 2,
   parameter int T_EXIT         = 2
) (
   input  logic                          clk_ser,
   input  logic                          resetb,
   input  logic                          enable,
   input  logic                          hs_req,
   input  logic [8*NUM_DATA_LANES-1:0]   data,
   output logic                          re,
   output logic                          busy,
   output logic                          mcp,
   output logic                          mcn,
   output logic [NUM_DATA_LANES-1:0]     mdp,
   output logic [NUM_DATA_LANES-1:0]     mdn,
   output logic [NUM_DATA_LANES-1:0]     mdp_lp,
   output logic [NUM_DATA_LANES-1:0]     mdn_lp,
   output logic [2:0]                    dbg_state
);

   // A timing parameter of zero is treated as one byte period.
   localparam int LPX_N  = (T_LPX < 1) ? 1 : T_LPX;
   localparam int PRP_N  = (T_PREPARE < 1) ? 1 : T_PREPARE;
   localparam int TRL_N  = (T_TRAIL < 1) ? 1 : T_TRAIL;
   localparam int EXT_N  = (T_EXIT < 1) ? 1 : T_EXIT;
   localparam int MAX_AB = (LPX_N > PRP_N) ? LPX_N : PRP_N;
   localparam int MAX_CD = (TRL_N > EXT_N) ? TRL_N : EXT_N;
   localparam int T_MAX  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [CNT_W-1:0] LPX_LAST = CNT_W'(LPX_N - 1);
   localparam logic [CNT_W-1:0] PRP_LAST = CNT_W'(PRP_N - 1);
   localparam logic [CNT_W-1:0] TRL_LAST = CNT_W'(TRL_N - 1);
   localparam logic [CNT_W-1:0] EXT_LAST = CNT_W'(EXT_N - 1);
   localparam logic [7:0]       SYNC_BYTE = 8'hB8;

   typedef enum logic [2:0] {
      ST_STOP    = 3'd0,
      ST_HS_RQST = 3'd1,
      ST_HS_PRPR = 3'd2,
      ST_SOT     = 3'd3,
      ST_HST     = 3'd4,
      ST_TRAIL   = 3'd5,
      ST_EXIT    = 3'd6
   } state_t;

   state_t                                state_q, state_d;
   logic [2:0]                            pos_q, pos_d;
   logic [CNT_W-1:0]                      cnt_q, cnt_d;
   logic [NUM_DATA_LANES-1:0][7:0]        byte_q, byte_d;
   logic                                  re_q, re_d;
   logic                                  busy_q, busy_d;
   logic                                  mcp_q, mcp_d;
   logic                                  mcn_q, mcn_d;
   logic [NUM_DATA_LANES-1:0]             mdp_q, mdp_d;
   logic [NUM_DATA_LANES-1:0]             mdn_q, mdn_d;
   logic [NUM_DATA_LANES-1:0]             mdp_lp_q, mdp_lp_d;
   logic [NUM_DATA_LANES-1:0]             mdn_lp_q, mdn_lp_d;
   logic                                  boundary;
   logic                                  hs_d;

   assign boundary = enable && (pos_q == 3'd7);

   always_ff @(posedge clk_ser) begin
      if (!resetb) begin
         state_q  <= ST_STOP;
         pos_q    <= '0;
         cnt_q    <= '0;
         byte_q   <= '0;
         re_q     <= 1'b0;
         busy_q   <= 1'b0;
         mcp_q    <= 1'b0;
         mcn_q    <= 1'b0;
         mdp_q    <= '0;
         mdn_q    <= '0;
         mdp_lp_q <= '1;
         mdn_lp_q <= '1;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         cnt_q    <= cnt_d;
         byte_q   <= byte_d;
         re_q     <= re_d;
         busy_q   <= busy_d;
         mcp_q    <= mcp_d;
         mcn_q    <= mcn_d;
         mdp_q    <= mdp_d;
         mdn_q    <= mdn_d;
         mdp_lp_q <= mdp_lp_d;
         mdn_lp_q <= mdn_lp_d;
      end
   end

   // Next state, byte-period counter and per-lane byte being shifted out.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      byte_d  = byte_q;
      pos_d   = enable ? (pos_q + 3'd1) : 3'd0;
      if (!enable) begin
         state_d = ST_STOP;
         cnt_d   = '0;
      end else if (boundary) begin
         case (state_q)
            ST_STOP: begin
               if (hs_req) begin
                  state_d = ST_HS_RQST;
                  cnt_d   = '0;
               end
            end
            ST_HS_RQST: begin
               if (!hs_req) begin
                  state_d = ST_EXIT;
                  cnt_d   = '0;
               end else if (cnt_q == LPX_LAST) begin
                  state_d = ST_HS_PRPR;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_HS_PRPR: begin
               if (!hs_req) begin
                  state_d = ST_EXIT;
                  cnt_d   = '0;
               end else if (cnt_q == PRP_LAST) begin
                  state_d = ST_SOT;
                  cnt_d   = '0;
                  for (int l = 0; l < NUM_DATA_LANES; l++) byte_d[l] = SYNC_BYTE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_SOT, ST_HST: begin
               if (hs_req) begin
                  state_d = ST_HST;
                  byte_d  = data;
               end else begin
                  // Trail holds the complement of the last bit on each lane.
                  state_d = ST_TRAIL;
                  cnt_d   = '0;
                  for (int l = 0; l < NUM_DATA_LANES; l++) byte_d[l] = {8{~byte_q[l][7]}};
               end
            end
            ST_TRAIL: begin
               if (cnt_q == TRL_LAST) begin
                  state_d = ST_EXIT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_EXIT: begin
               if (cnt_q == EXT_LAST) begin
                  state_d = ST_STOP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_STOP;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Handshake: data is sampled on the byte-boundary edge and re pulses for
   // the following cycle so the source can present the next byte.
   always_comb begin
      hs_d   = (state_d == ST_SOT) || (state_d == ST_HST) || (state_d == ST_TRAIL);
      re_d   = boundary && hs_req && ((state_q == ST_SOT) || (state_q == ST_HST));
      busy_d = (state_d != ST_STOP);
      for (int l = 0; l < NUM_DATA_LANES; l++) begin
         mdp_d[l] = hs_d & byte_d[l][pos_d];
         mdn_d[l] = hs_d & ~byte_d[l][pos_d];
      end
      case (state_d)
         ST_HS_RQST: begin
            mdp_lp_d = '0;
            mdn_lp_d = '1;
         end
         ST_HS_PRPR, ST_SOT, ST_HST, ST_TRAIL: begin
            mdp_lp_d = '0;
            mdn_lp_d = '0;
         end
         default: begin
            mdp_lp_d = '1;
            mdn_lp_d = '1;
         end
      endcase
`ifdef MIPI_PHY_SER_MULTILANE_CONT_CLK_EN
      mcp_d = enable & ~mcp_q;
      mcn_d = enable & ~mcp_d;
`else
      mcp_d = hs_d & ~mcp_q;
      mcn_d = hs_d & ~mcp_d;
`endif
   end

   assign re        = re_q;
   assign busy      = busy_q;
   assign mcp       = mcp_q;
   assign mcn       = mcn_q;
   assign mdp       = mdp_q;
   assign mdn       = mdn_q;
   assign mdp_lp    = mdp_lp_q;
   assign mdn_lp    = mdn_lp_q;
   assign dbg_state = state_q;

endmodule

// File: doc/mipi_phy_ser_multilane.md
MIPI_PHY_SER_MULTILANE -- requirements
Module: mipi_phy_ser_multilane

Interface
REQ-001 Parameter NUM_DATA_LANES, default 1, number of data lanes (legal 1..4).
REQ-002 Parameter T_LPX, default 2, LP-01 duration in byte periods (8 clk_ser cycles each).
REQ-003 Parameter T_PREPARE, default 1, LP-00 duration in byte periods.
REQ-004 Parameter T_TRAIL, default 2, HS-trail duration in byte periods.
REQ-005 Parameter T_EXIT, default 2, post-burst LP-11 hold in byte periods.
REQ-006 clk_ser  input  1  bit-rate clock; the only clock. Reset is synchronous and active-low.
REQ-007 resetb  input  1  synchronous active-low reset.
REQ-008 enable  input  1  block enable.
REQ-009 hs_req  input  1  request/continue HS burst.
REQ-010 data  input  8*NUM_DATA_LANES  payload; lane l takes data[8l+7:8l].
REQ-011 re  output  1  one-cycle byte-consume strobe.
REQ-012 busy  output  1  high whenever state != STOP.
REQ-013 mcp, mcn  output  1 each  clock-lane pair.
REQ-014 mdp, mdn  output  NUM_DATA_LANES each  HS data pairs.
REQ-015 mdp_lp, mdn_lp  output  NUM_DATA_LANES each  LP data lines.

Function
REQ-016 3-bit pos counter SHALL increment every cycle while enable=1, wrapping 7->0; byte boundary = cycle with pos==7.
REQ-017 States STOP, HS_RQST, HS_PRPR, SOT, HST, TRAIL, EXIT; transitions SHALL occur only at byte boundaries except per REQ-028.
REQ-018 STOP: LP-11 on all lanes; hs_req=1 at boundary -> HS_RQST.
REQ-019 HS_RQST: LP-01 (mdp_lp=0, mdn_lp=1) for T_LPX byte periods -> HS_PRPR.
REQ-020 HS_PRPR: LP-00 for T_PREPARE byte periods -> SOT; hs_req=0 at any boundary in HS_RQST/HS_PRPR -> EXIT (abort, no HS bits, no re).
REQ-021 SOT: every lane SHALL transmit sync byte 0xB8 LSB first (bits 0,0,0,1,1,1,0,1).
REQ-022 At the last SOT boundary and each HST boundary with hs_req=1: re=1 for that cycle, data captured, state HST; bit k of the captured byte appears on mdp[l] at boundary+1+k.
REQ-023 HST boundary with hs_req=0: re stays 0, each lane loads {8{~last bit sent}}, state TRAIL for T_TRAIL byte periods.
REQ-024 After TRAIL: LP-11 on all lanes, state EXIT for T_EXIT byte periods, hs_req ignored, then STOP.
REQ-025 In HS states (SOT, HST, TRAIL): mdp_lp=mdn_lp=0, mdp=bit, mdn=~bit; in LP states mdp=mdn=0.
REQ-026 Clock lane in SOT..TRAIL: mcp toggles every cycle, mcn=~mcp; otherwise per REQ-032.
REQ-027 Any timing parameter of 0 SHALL behave as 1.
REQ-028 enable=0 in any state: next cycle state=STOP, pos=0, re=0, LP-11, mdp=mdn=0, clock lane idle.
REQ-029 All outputs registered; no combinational input-to-output path.

Reset
REQ-030 resetb=0 at posedge clk_ser: state=STOP, pos=0, re=0, busy=0, mdp_lp=mdn_lp=all 1, mdp=mdn=0, mcp=mcn=0; reset mid-burst aborts with no trail.

Configuration
REQ-031 Macro MIPI_PHY_SER_MULTILANE_CONT_CLK_EN selects clock-lane mode.
REQ-032 Defined: mcp/mcn toggle continuously whenever enable=1, all states. Undefined: outside SOT..TRAIL mcp=mcn=0.

Verification
REQ-033 Reset asserted 3 cycles -> mdp_lp=mdn_lp=1, mdp=mdn=0, re=0, busy=0.
REQ-034 1 lane, defaults, hs_req=1, bytes 0x11,0x22,0x33 -> LP-01 16 cycles, LP-00 8, 0xB8 LSB first, three re pulses 8 cycles apart, bytes serialised LSB first.
REQ-035 4 lanes, data=0xA55A0FF0 one byte -> lane0 sends 0xF0, lane1 0x0F, lane2 0x5A, lane3 0xA5, all in phase.
REQ-036 Last byte 0x80 then hs_req=0 -> trail 0x00 (mdp=0) 16 cycles, LP-11 16 cycles, then STOP, busy falls.
REQ-037 hs_req dropped during HS_PRPR -> EXIT, no HS bits, re never asserted; enable dropped mid-HST -> LP-11 next cycle.
REQ-038 With macro defined, mcp toggles in STOP; without it, mcp=mcn=0 in STOP.
